control_unit_pipe: RTL

//  Next-gen RV32I control unit: decodes op/funct3/funct7, registers the control bundle into the ID/EX stage.

---
 rtl/control_unit_pipe.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/control_unit_pipe.sv
// control_unit_pipe: RV32I control decode with a registered ID/EX control bundle.
//  Decodes instr_d, drives the combinational immediate select for the ID extender,
//  detects load-use hazards, and registers the control bundle into the E stage
//  with flush/stall handling.
// Ports:
//  clk, rst                 clock, asynchronous active-high reset
//  instr_d, valid_d         decode-stage instruction and its valid flag
//  stall_i, flush_i         external hold / kill of the E register
//  ImmSrcD                  combinational immediate select (000 I,001 S,010 B,011 J,100 U)
//  stall_o                  combinational load-use stall request to IF/ID
//  RegWriteE..illegal_e     registered E-stage control bundle
module control_unit_pipe #(
   parameter int unsigned ALU_CTRL_W = 4,
   parameter bit          HAZARD_EN  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           instr_d,
   input  logic                  valid_d,
   input  logic                  stall_i,
   input  logic                  flush_i,
   output logic [2:0]            ImmSrcD,
   output logic                  stall_o,
   output logic                  RegWriteE,
   output logic [1:0]            ResultSrcE,
   output logic                  MemWriteE,
   output logic                  ALUSrcE,
   output logic                  BranchE,
   output logic                  JumpE,
   output logic                  JalrE,
   output logic                  PcSrcAE,
   output logic [ALU_CTRL_W-1:0] ALUControlE,
   output logic [4:0]            rdE,
   output logic                  valid_e,
   output logic                  illegal_e
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] RS_MEM = 2'b01;
   localparam logic [1:0] RS_PC4 = 2'b10;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_AND   = 4'd2;
   localparam logic [3:0] ALU_OR    = 4'd3;
   localparam logic [3:0] ALU_XOR   = 4'd4;
   localparam logic [3:0] ALU_SLT   = 4'd5;
   localparam logic [3:0] ALU_SLTU  = 4'd6;
   localparam logic [3:0] ALU_SLL   = 4'd7;
   localparam logic [3:0] ALU_SRL   = 4'd8;
   localparam logic [3:0] ALU_SRA   = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   typedef struct packed {
      logic       valid;
      logic       illegal;
      logic       reg_write;
      logic [1:0] result_src;
      logic       mem_write;
      logic       alu_src;
      logic       branch;
      logic       jump;
      logic       jalr;
      logic       pc_src_a;
      logic [3:0] alu_ctrl;
      logic [4:0] rd;
   } ctrl_t;

   logic [6:0] op;
   logic [2:0] f3;
   logic [6:0] f7;
   logic [4:0] rs1;
   logic [4:0] rs2;
   assign op  = instr_d[6:0];
   assign f3  = instr_d[14:12];
   assign rs1 = instr_d[19:15];
   assign rs2 = instr_d[24:20];
   assign f7  = instr_d[31:25];

   ctrl_t      dec;
   ctrl_t      e_q;
   ctrl_t      e_next;
   logic [2:0] imm_src;
   logic       uses_rs1;
   logic       uses_rs2;
   logic [3:0] alu_funct;
   logic       bad_funct;
   logic       load_use;

   // ALU op and funct legality shared by R-type and I-type ALU instructions
   always_comb begin : funct_decode
      logic is_r;
      logic f7_zero;
      logic f7_alt;
      is_r      = (op == OP_RTYPE);
      f7_zero   = (f7 == 7'b0000000);
      f7_alt    = (f7 == 7'b0100000);
      alu_funct = ALU_ADD;
      case (f3)
         3'b000:  alu_funct = (is_r && f7_alt) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_funct = ALU_SLL;
         3'b010:  alu_funct = ALU_SLT;
         3'b011:  alu_funct = ALU_SLTU;
         3'b100:  alu_funct = ALU_XOR;
         3'b101:  alu_funct = f7[5] ? ALU_SRA : ALU_SRL;
         3'b110:  alu_funct = ALU_OR;
         default: alu_funct = ALU_AND;
      endcase
      // R-type only allows the alternate f7 on sub/sra; immediates only constrain shifts
      if (is_r)
         bad_funct = !(f7_zero || (f7_alt && ((f3 == 3'b000) || (f3 == 3'b101))));
      else
         bad_funct = ((f3 == 3'b001) && !f7_zero) ||
                     ((f3 == 3'b101) && !(f7_zero || f7_alt));
   end

   // Main opcode decode into the control bundle
   always_comb begin : main_decode
      dec      = '0;
      dec.valid = 1'b1;
      dec.rd   = instr_d[11:7];
      imm_src  = IMM_I;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      case (op)
         OP_LOAD: begin
            dec.reg_write  = 1'b1;
            dec.result_src = RS_MEM;
            dec.alu_src    = 1'b1;
            uses_rs1       = 1'b1;
         end
         OP_STORE: begin
            imm_src       = IMM_S;
            dec.mem_write = 1'b1;
            dec.alu_src   = 1'b1;
            uses_rs1      = 1'b1;
            uses_rs2      = 1'b1;
         end
         OP_RTYPE: begin
            dec.reg_write = 1'b1;
            dec.alu_ctrl  = alu_funct;
            dec.illegal   = bad_funct;
            uses_rs1      = 1'b1;
            uses_rs2      = 1'b1;
         end
         OP_ITYPE: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.alu_ctrl  = alu_funct;
            dec.illegal   = bad_funct;
            uses_rs1      = 1'b1;
         end
         OP_BR: begin
            imm_src      = IMM_B;
            dec.branch   = 1'b1;
            dec.alu_ctrl = ALU_SUB;
            uses_rs1     = 1'b1;
            uses_rs2     = 1'b1;
         end
         OP_JAL: begin
            imm_src        = IMM_J;
            dec.jump       = 1'b1;
            dec.reg_write  = 1'b1;
            dec.result_src = RS_PC4;
         end
         OP_JALR: begin
            dec.jump       = 1'b1;
            dec.jalr       = 1'b1;
            dec.alu_src    = 1'b1;
            dec.reg_write  = 1'b1;
            dec.result_src = RS_PC4;
            uses_rs1       = 1'b1;
         end
         OP_LUI: begin
            imm_src       = IMM_U;
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
            dec.alu_ctrl  = ALU_PASSB;
         end
         OP_AUIPC: begin
            imm_src       = IMM_U;
            dec.alu_src   = 1'b1;
            dec.pc_src_a  = 1'b1;
            dec.reg_write = 1'b1;
         end
         default: dec.illegal = 1'b1;
      endcase
      // Illegal instructions travel down the pipe with no side effects
      if (dec.illegal) begin
         dec.reg_write  = 1'b0;
         dec.result_src = 2'b00;
         dec.mem_write  = 1'b0;
         dec.alu_src    = 1'b0;
         dec.alu_ctrl   = ALU_ADD;
         imm_src        = IMM_I;
      end
   end

   assign ImmSrcD = imm_src;

   // Load in E whose destination feeds the instruction currently in decode
   assign load_use = e_q.valid && (e_q.result_src == RS_MEM) && (e_q.rd != 5'd0) && valid_d &&
                     (((e_q.rd == rs1) && uses_rs1) || ((e_q.rd == rs2) && uses_rs2));
   assign stall_o  = HAZARD_EN ? load_use : 1'b0;

   // E-register next value: flush > stall_i hold > load-use bubble > decode
   always_comb begin : e_next_sel
      e_next = e_q;
      if (flush_i)       e_next = '0;
      else if (stall_i)  e_next = e_q;
      else if (stall_o)  e_next = '0;
      else if (!valid_d) e_next = '0;
      else               e_next = dec;
   end

   always_ff @(posedge clk or posedge rst) begin : e_reg
      if (rst) e_q <= '0;
      else     e_q <= e_next;
   end

   assign valid_e     = e_q.valid;
   assign illegal_e   = e_q.illegal;
   assign RegWriteE   = e_q.reg_write;
   assign ResultSrcE  = e_q.result_src;
   assign MemWriteE   = e_q.mem_write;
   assign ALUSrcE     = e_q.alu_src;
   assign BranchE     = e_q.branch;
   assign JumpE       = e_q.jump;
   assign JalrE       = e_q.jalr;
   assign PcSrcAE     = e_q.pc_src_a;
   assign ALUControlE = ALU_CTRL_W'(e_q.alu_ctrl);
   assign rdE         = e_q.rd;

endmodule
